// File: rtl/connector_wr_merge.sv
// connector_wr_merge
//   Buffers per-channel writes in small FIFOs and merges them, round-robin, onto
//   one registered valid/ready stream tagged with the source channel.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   wen        per-channel write enable (bit k -> channel k)
//   data       channel k payload at data[k*DATA_W +: DATA_W]
//   freeze     blocks loading of the output register
//   ovf_clr    clears all sticky overflow bits
//   out_ready  downstream accepts the held entry
//   out_valid  output register holds an entry
//   out_data   payload of the held entry
//   out_chan   source channel of the held entry
//   full       FIFO k holds DEPTH entries
//   overflow   sticky, set when a write to a full FIFO is dropped
module connector_wr_merge #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        wen,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic                  freeze,
  input  logic                  ovf_clr,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [CW-1:0]         out_chan,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [NCH-1:0][AW:0]                    wptr_q, rptr_q;
  logic [NCH-1:0][DEPTH-1:0][DATA_W-1:0]   mem_q;
  logic [CW-1:0]                           rr_ptr_q;

  logic [NCH-1:0]     empty, push, drop, pop;
  logic [2*NCH-1:0]   ne_dbl, ne_rot;
  logic               any_ne, load;
  int unsigned        gnt;
  logic [DATA_W-1:0]  head;

  // FIFO status; fullness is judged before any pop in the same cycle.
  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    drop  = '0;
    for (int k = 0; k < NCH; k++) begin
      empty[k] = (wptr_q[k] == rptr_q[k]);
      full[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                 (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
      push[k]  = wen[k] && !full[k];
      drop[k]  = wen[k] && full[k];
    end
  end

  // Round-robin search: rotate the non-empty mask so bit i is channel (ptr+i) mod NCH.
  always_comb begin
    ne_dbl = {~empty, ~empty};
    ne_rot = ne_dbl >> rr_ptr_q;
    gnt    = 0;
    any_ne = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!any_ne && ne_rot[i]) begin
        any_ne = 1'b1;
        gnt    = (32'(rr_ptr_q) + i) % NCH;
      end
    end
  end

  assign load = (!out_valid || out_ready) && !freeze && any_ne;

  always_comb begin
    pop  = '0;
    head = '0;
    for (int k = 0; k < NCH; k++) begin
      if (load && (gnt == k)) begin
        pop[k] = 1'b1;
        head   = mem_q[k][rptr_q[k][AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rr_ptr_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      overflow  <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (push[k]) wptr_q[k] <= wptr_q[k] + 1'b1;
        if (pop[k])  rptr_q[k] <= rptr_q[k] + 1'b1;
      end
      // A drop in the same cycle as ovf_clr keeps its bit set.
      overflow <= (overflow & ~{NCH{ovf_clr}}) | drop;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head;
        out_chan  <= CW'(gnt);
        rr_ptr_q  <= CW'((gnt + 1) % NCH);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (push[k]) mem_q[k][wptr_q[k][AW-1:0]] <= data[k*DATA_W +: DATA_W];
    end
  end

endmodule
